// File: rtl/seq_pkg.sv
// Shared definitions for the serial word transmitter and its downstream detector.
// Holds the 2-bit FSM state encoding and the default idle line level.
// No ports; import with seq_pkg::*.
package seq_pkg;

  // Value 2'd3 is unused; the FSM treats it as illegal and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Level driven on the serial line when no bit is being sent.
  localparam logic IDLE_LEVEL_DFLT = 1'b0;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out transmitter: takes WIDTH-bit words over valid/ready and
// shifts them out MSB-first, one bit per clk, with no gap between back-to-back words.
// Latency: word accepted at edge N shows din[WIDTH-1] in the cycle after edge N.
// Backpressure: din_ready only in IDLE and in the final-bit cycle (or the parity
// cycle when SERIAL_WORD_TX_PARITY_EN is defined), never while clr is high.
// Optional feature: define SERIAL_WORD_TX_PARITY_EN to append one even-parity bit.
// Ports:
//   clk, clr            clock and synchronous active-high reset
//   din_valid, din      upstream word and its valid flag
//   din_ready           block can take a word this cycle (combinational)
//   d_out, d_valid      serial bit and its qualifier (registered)
//   busy                word in flight (registered)
//   done                one-cycle pulse on the final bit of a word (registered)
module serial_word_tx
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DFLT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             d_out_nxt, d_valid_nxt, done_nxt;
  logic             accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
  // Parity is captured at load time because the shift register is consumed bit by bit.
  logic             par, par_nxt;
`endif

  // Ready is combinational so the next word can be taken in the last-bit cycle
  // and its MSB follows immediately.
  always_comb begin
    din_ready = 1'b0;
    if (!clr) begin
      case (state)
        ST_IDLE:  din_ready = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
        ST_PAR:   din_ready = 1'b1;
`else
        ST_SHIFT: din_ready = (cnt == '0);
`endif
        default:  din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid && din_ready;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
    par_nxt   = par;
`endif

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
          shreg_nxt = din;
          cnt_nxt   = CW'(WIDTH - 1);
`ifdef SERIAL_WORD_TX_PARITY_EN
          par_nxt   = ^din;
`endif
        end
      end
      ST_SHIFT: begin
        if (cnt != '0) begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          cnt_nxt   = cnt - 1'b1;
        end else if (accept) begin
          // Reload on the last bit: next word continues without an idle cycle.
          shreg_nxt = din;
          cnt_nxt   = CW'(WIDTH - 1);
        end else begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
`ifdef SERIAL_WORD_TX_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      ST_PAR: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
          shreg_nxt = din;
          cnt_nxt   = CW'(WIDTH - 1);
          par_nxt   = ^din;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    d_out_nxt   = IDLE_LEVEL;
    d_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state_nxt)
      ST_SHIFT: begin
        d_out_nxt   = shreg_nxt[WIDTH-1];
        d_valid_nxt = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
        done_nxt    = (cnt_nxt == '0);
`endif
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      ST_PAR: begin
        d_out_nxt   = par_nxt;
        d_valid_nxt = 1'b1;
        done_nxt    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      d_out   <= IDLE_LEVEL;
      d_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      d_out   <= d_out_nxt;
      d_valid <= d_valid_nxt;
      busy    <= d_valid_nxt;
      done    <= done_nxt;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx (WIDTH=8): directed steps plus a randomized phase,
// checked against a queue of expected serial bits built from each accepted word.
// Honours SERIAL_WORD_TX_PARITY_EN the same way the design does.
module tb_serial_word_tx;
  localparam int   W  = 8;
  localparam logic IL = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_ready, d_out, d_valid, busy, done;

  serial_word_tx #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
    .clk(clk), .clr(clr), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .d_out(d_out), .d_valid(d_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; logic dn; } rec_t;
  rec_t   q[$];            // bits still to appear; q[0] is the current cycle's bit
  int     checks = 0;
  int     failures = 0;
  logic [31:0] obs_bits;   // every bit seen with d_valid=1, newest in bit 0
  int     exp_dones = 0;
  int     obs_dones = 0;
  logic   last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one accepted word as the sequence of bits it produces on the line.
  task automatic push_word(input logic [W-1:0] w);
    rec_t r;
    for (int i = W - 1; i >= 0; i--) begin
      r.b  = w[i];
      r.dn = (i == 0) && !PAR_EN;
      q.push_back(r);
    end
    if (PAR_EN) begin
      r.b  = ^w;
      r.dn = 1'b1;
      q.push_back(r);
    end
    exp_dones++;
  endtask

  // One clock: drive inputs at negedge, check at negedge+1, advance model at posedge.
  task automatic cycle(input logic c, input logic v, input logic [W-1:0] w);
    logic exp_rdy;
    clr = c; din_valid = v; din = w;
    #1;
    exp_rdy = !c && (q.size() <= 1);
    chk("din_ready", 32'(din_ready), 32'(exp_rdy));
    if (q.size() > 0) begin
      chk("d_out", 32'(d_out), 32'(q[0].b));
      chk("d_valid", 32'(d_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(q[0].dn));
    end else begin
      chk("idle_d_out", 32'(d_out), 32'(IL));
      chk("idle_d_valid", 32'(d_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
    if (d_valid === 1'b1) obs_bits = {obs_bits[30:0], d_out};
    if (done === 1'b1) obs_dones++;
    @(posedge clk);
    last_acc = 1'b0;
    if (c) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && exp_rdy) begin
        push_word(w);
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Hold din_valid high with a stable word until the model says it is taken.
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    logic r;
    do begin
      r = (q.size() <= 1);
      cycle(1'b0, 1'b1, w);
      n++;
    end while (!r && n < 40);
    if (!r) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] exp_bits;
    logic [W-1:0] rw;
    logic rv, rc;

    // First reset edge: outputs are unknown beforehand, so no checks yet.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cycle(1'b1, 1'b0, '0);
    idle(2);

    // Single word 8'hAA.
    obs_bits = '0;
    send(8'hAA);
    idle(12);
    exp_bits = PAR_EN ? 32'({8'hAA, ^8'hAA}) : 32'h0000_00AA;
    chk("stream_AA", obs_bits, exp_bits);

    // Back-to-back 8'h0A then 8'hA0 with din_valid held high.
    obs_bits = '0;
    send(8'h0A);
    send(8'hA0);
    idle(12);
    exp_bits = PAR_EN ? 32'({8'h0A, ^8'h0A, 8'hA0, ^8'hA0}) : 32'h0000_0AA0;
    chk("stream_0A_A0", obs_bits, exp_bits);

    // Reset during bit 4 of 8'hFF, then a clean restart.
    send(8'hFF);
    idle(3);
    cycle(1'b1, 1'b0, '0);
    idle(2);
    obs_bits = '0;
    send(8'h3C);
    idle(12);
    exp_bits = PAR_EN ? 32'({8'h3C, ^8'h3C}) : 32'h0000_003C;
    chk("stream_after_clr", obs_bits, exp_bits);

    // Held-off word: second send waits through the first word's data bits.
    send(8'hC3);
    send(8'h5A);
    idle(12);

`ifdef SERIAL_WORD_TX_PARITY_EN
    obs_bits = '0;
    send(8'hA5);
    idle(12);
    chk("parity_A5", obs_bits[8:0], 32'({8'hA5, 1'b0}));
    obs_bits = '0;
    send(8'hA4);
    idle(12);
    chk("parity_A4", obs_bits[8:0], 32'({8'hA4, 1'b1}));
`endif

    // Randomized traffic; din stays stable while valid is pending.
    rv = 1'b0;
    rw = '0;
    last_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!rv || last_acc) begin
        rv = ($urandom_range(0, 3) != 0);
        rw = W'($urandom);
      end
      rc = ($urandom_range(0, 59) == 0);
      cycle(rc, rv, rw);
      if (rc) rv = 1'b0;
    end
    idle(12);

    // Words cut by clr produce no done, so count only completed words.
    chk("done_count_min", 32'(obs_dones <= exp_dones), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in/serial-out transmitter that produces the one-bit-per-clock `d` stream consumed by the downstream 1010 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first.
- Back-to-back words leave no idle gap, so patterns that straddle a word boundary stay detectable downstream.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- IDLE_LEVEL, 1'b0, value driven on d_out when no bit is being sent.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset, sampled on the clk rising edge.
- din_valid  input  1  upstream word present on din.
- din  input  WIDTH  parallel word; sampled only when din_valid && din_ready.
- din_ready  output  1  block can accept a word this cycle.
- d_out  output  1  serial bit; connects to the detector's d input.
- d_valid  output  1  d_out carries a data or parity bit this cycle.
- busy  output  1  a word is in flight (SHIFT or PAR state).
- done  output  1  one-cycle pulse coincident with the final bit of a word.

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE, shift register=0, bit counter=0.
  - d_out=IDLE_LEVEL, d_valid=0, busy=0, done=0 (all registered).
  - din_ready=0 while clr is high.
  - Reset mid-word discards the word; no done pulse is produced.
- States (2-bit encoding): IDLE=0, SHIFT=1, PAR=2; 3 is illegal and returns to IDLE.
- IDLE:
  - din_ready=1.
  - On accept: load shreg<=din, cnt<=WIDTH-1, go to SHIFT.
- SHIFT:
  - Registered outputs present d_out=shreg[WIDTH-1], d_valid=1, busy=1.
  - Each edge: shreg shifts left (zero fill), cnt decrements.
  - din_ready=1 only when cnt==0, i.e. the last-bit cycle and no parity.
  - When cnt==0:
    - With an accept: reload and stay in SHIFT.
    - Without an accept: go to IDLE, or to PAR if parity is enabled.
- Latency:
  - A word accepted at edge N puts din[WIDTH-1] on d_out in the cycle after edge N.
  - din[0] appears in the cycle after edge N+WIDTH-1.
  - done=1 in that same cycle (or in the parity cycle when parity is enabled).
- Back-to-back accept: the next word's MSB follows the previous word's last bit in the very next cycle; d_valid stays 1.
- On return to IDLE: d_out=IDLE_LEVEL and d_valid=0 from the next cycle.
- din_valid while din_ready=0 is held off; upstream keeps din stable (standard valid/ready rule).
- din_valid may deassert without a transfer.
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- When defined:
  - After bit 0, the block enters PAR for one cycle.
  - d_out = even parity (XOR of the word), d_valid=1, busy=1, done=1.
  - din_ready=1 only in PAR; an accept there goes straight to SHIFT with no gap.
  - The bit-0 cycle has done=0 and din_ready=0.
- When undefined: the PAR state and parity logic are absent; done and din_ready assert in the bit-0 cycle.

Decomposition:
- Shared package seq_pkg holds:
  - state encodings ST_IDLE, ST_SHIFT, ST_PAR;
  - IDLE_LEVEL default.
- The bit counter and shift register stay inline; no sub-module is needed.
- The top-level pairing of serial_word_tx with the detector lives in the integration wrapper, not in this block.

Test Plan:
- clr=1 for 2 cycles, then clr=0 with din_valid=0 → d_out=0, d_valid=0, busy=0, done=0, din_ready=1.
- WIDTH=8, load 8'hAA once → d_out=1,0,1,0,1,0,1,0 on 8 consecutive cycles; done on the 8th; downstream detector y fires for the embedded 1010 occurrences.
- Back-to-back 8'h0A then 8'hA0 with din_valid held high → 16 contiguous bits 00001010 10100000, d_valid never drops, done pulses at bits 8 and 16.
- Assert clr during bit 4 of 8'hFF → the next cycle shows d_out=IDLE_LEVEL, d_valid=0, no done; a new word then starts cleanly.
- din_valid held high during SHIFT with cnt≠0 → din_ready=0, no reload; the word is taken only at the last-bit cycle.
- SERIAL_WORD_TX_PARITY_EN defined, load 8'hA5 → 8 data bits, then a parity bit of 0; load 8'hA4 → parity bit 1; done only in the parity cycle.
